// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// quad_pkg : shared types, AB codes and direction decode for quad_decoder
// Revision : 1.0
// ============================================================================
package quad_pkg;

  typedef enum logic {INIT, TRACK} quad_state_t;

  typedef enum logic [1:0] {NONE, CW, CCW, ILLEGAL} quad_dir_t;

  localparam logic [1:0] c_AB_00 = 2'b00;
  localparam logic [1:0] c_AB_01 = 2'b01;
  localparam logic [1:0] c_AB_10 = 2'b10;
  localparam logic [1:0] c_AB_11 = 2'b11;

  // Codes are {a,b}; CW walks 00->10->11->01->00, the reverse walk is CCW.
  function automatic quad_dir_t quad_dir(input logic [1:0] prev, input logic [1:0] curr);
    quad_dir_t dir;
    dir = NONE;
    if (prev == curr) begin
      dir = NONE;
    end else if ((prev ^ curr) == 2'b11) begin
      dir = ILLEGAL;
    end else begin
      case (prev)
        c_AB_00: dir = (curr == c_AB_10) ? CW : CCW;
        c_AB_10: dir = (curr == c_AB_11) ? CW : CCW;
        c_AB_11: dir = (curr == c_AB_01) ? CW : CCW;
        c_AB_01: dir = (curr == c_AB_00) ? CW : CCW;
        default: dir = NONE;
      endcase
    end
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// debounce_filter : single-channel stable-count filter for quad_decoder
// Revision : 1.0
// ============================================================================
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [7:0] r_cnt;
  logic       r_q;

  // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample; the
  // count never passes DEBOUNCE_CYCLES-1, so it cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt >= 8'(DEBOUNCE_CYCLES - 1)) begin
      r_q   <= d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// quad_decoder : A/B quadrature synchroniser, optional filter, cw/ccw/err decode
// Build option : QUAD_DEBOUNCE_EN adds a debounce_filter per channel
// Revision     : 1.0
// ============================================================================
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic cw,
  output logic ccw,
  output logic err
);

  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  w_ab;
  logic        w_settled;
  logic [1:0]  r_prev;
  logic [1:0]  r_warm;
  quad_state_t r_state;
  quad_state_t w_next_state;
  quad_dir_t   w_dir;
  logic        w_load_prev;
  logic        w_cw;
  logic        w_ccw;
  logic        w_err;
  logic        r_cw;
  logic        r_ccw;
  logic        r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {enc_a, enc_b};
      r_sync2 <= r_sync1;
    end
  end

`ifdef QUAD_DEBOUNCE_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (r_sync2[gi]),
      .q      (w_ab[gi])
    );
  end : g_filt
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^DEBOUNCE_CYCLES;
  assign w_ab         = r_sync2;
`endif

  // The filter restarts from 0, so INIT also waits for it to catch up with
  // the pin level; otherwise a resting level of 11 would decode as a jump.
  assign w_settled = (w_ab == r_sync2);
  assign w_dir     = quad_dir(r_prev, w_ab);

  always_comb begin
    w_next_state = r_state;
    w_load_prev  = 1'b0;
    w_cw         = 1'b0;
    w_ccw        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      INIT: begin
        if ((r_warm == 2'd2) && w_settled) begin
          w_next_state = TRACK;
          w_load_prev  = 1'b1;
        end
      end
      TRACK: begin
        w_load_prev = 1'b1;
        case (w_dir)
          CW:      w_cw  = 1'b1;
          CCW:     w_ccw = 1'b1;
          ILLEGAL: w_err = 1'b1;
          default: ;
        endcase
      end
      default: w_next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_warm  <= '0;
      r_prev  <= '0;
      r_cw    <= 1'b0;
      r_ccw   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cw    <= w_cw;
      r_ccw   <= w_ccw;
      r_err   <= w_err;
      if ((r_state == INIT) && (r_warm != 2'd2)) begin
        r_warm <= r_warm + 2'd1;
      end
      if (w_load_prev) begin
        r_prev <= w_ab;
      end
    end
  end

  assign cw  = r_cw;
  assign ccw = r_ccw;
  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// tb_quad_decoder : scoreboard bench, directed A/B vectors for quad_decoder
// Revision : 1.0
// ============================================================================
module tb_quad_decoder;

  localparam int DEB = 4;
`ifdef QUAD_DEBOUNCE_EN
  localparam int LAT  = 3 + DEB;
  localparam int FAST = 10;
`else
  localparam int LAT  = 3;
  localparam int FAST = 1;
`endif

  localparam int K_NONE = 0;
  localparam int K_CW   = 1;
  localparam int K_CCW  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  logic enc_a;
  logic enc_b;
  logic cw;
  logic ccw;
  logic err;

  int   cyc;
  int   errors;
  int   checks;
  int   n_cw;
  int   n_ccw;
  int   n_err;
  exp_t sb[$];

  quad_decoder #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .cw     (cw),
    .ccw    (ccw),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever any output pulses.
  always @(negedge clk) begin
    int   got;
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: got no pulse, required kind %0d at cycle %0d (now %0d)",
               sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (cw || ccw || err) begin
      got = cw ? K_CW : (ccw ? K_CCW : K_ERR);
      if (cw)  n_cw++;
      if (ccw) n_ccw++;
      if (err) n_err++;
      checks++;
      if ($countones({cw, ccw, err}) != 1) begin
        errors++;
        $display("FAIL exclusive: got cw=%0b ccw=%0b err=%0b, required one-hot", cw, ccw, err);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", got, cyc);
      end else begin
        e = sb.pop_front();
        if (e.kind != got || e.cyc != cyc) begin
          errors++;
          $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   got, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] ab, input int kind, input int hold);
    exp_t e;
    enc_a = ab[1];
    enc_b = ab[0];
    if (kind != K_NONE) begin
      e.kind = kind;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic check_quiet(input string name);
    check_int(name, int'({cw, ccw, err}), 0);
  endtask

  int b_cw;
  int b_ccw;
  int b_err;

  task automatic mark();
    b_cw  = n_cw;
    b_ccw = n_ccw;
    b_err = n_err;
  endtask

  task automatic check_counts(input string name, input int ecw, input int eccw, input int eerr);
    check_int({name, "_cw"},  n_cw  - b_cw,  ecw);
    check_int({name, "_ccw"}, n_ccw - b_ccw, eccw);
    check_int({name, "_err"}, n_err - b_err, eerr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors  = 0;
    checks  = 0;
    n_cw    = 0;
    n_ccw   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    enc_a   = 1'b1;
    enc_b   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    reset_n = 1'b1;

    // Resting level 11 after reset: no pulse.
    mark();
    drive(2'b11, K_NONE, 20);
    check_counts("rest11", 0, 0, 0);

    // 11 -> 00 is a double change, then one CW detent.
    mark();
    drive(2'b00, K_ERR, 10);
    drive(2'b10, K_CW,  10);
    drive(2'b11, K_CW,  10);
    drive(2'b01, K_CW,  10);
    drive(2'b00, K_CW,  10);
    check_counts("cw_detent", 4, 0, 1);

    // Two CCW detents followed by one CW detent.
    mark();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, K_CCW, 10);
      drive(2'b11, K_CCW, 10);
      drive(2'b10, K_CCW, 10);
      drive(2'b00, K_CCW, 10);
    end
    drive(2'b10, K_CW, 10);
    drive(2'b11, K_CW, 10);
    drive(2'b01, K_CW, 10);
    drive(2'b00, K_CW, 10);
    check_counts("ccw_ccw_cw", 4, 8, 0);

    // Illegal jump 00 -> 11, then 11 -> 01 proves resynchronisation.
    mark();
    drive(2'b11, K_ERR, 10);
    drive(2'b01, K_CW,  10);
    check_counts("illegal", 1, 0, 1);

    // Fastest rate: one step per cycle from 01.
    mark();
    drive(2'b00, K_CW, FAST);
    drive(2'b10, K_CW, FAST);
    drive(2'b11, K_CW, FAST);
    drive(2'b01, K_CW, FAST);
    drive(2'b00, K_CW, 12);
    check_counts("back_to_back", 5, 0, 0);

    mark();
`ifdef QUAD_DEBOUNCE_EN
    drive(2'b10, K_NONE, 3);
    drive(2'b00, K_NONE, 15);
    check_counts("glitch3", 0, 0, 0);
    mark();
    drive(2'b10, K_CW,  5);
    drive(2'b00, K_CCW, 15);
    check_counts("glitch5", 1, 1, 0);
`else
    drive(2'b10, K_CW,  1);
    drive(2'b00, K_CCW, 10);
    check_counts("pulse1", 1, 1, 0);
`endif

    // Reset one cycle before an expected cw; new pin level 01 after release.
    mark();
    drive(2'b10, K_NONE, LAT - 1);
    reset_n = 1'b0;
    #1;
    check_quiet("mid_reset_async");
    enc_a = 1'b0;
    enc_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("mid_reset_hold");
    reset_n = 1'b1;
    drive(2'b01, K_NONE, 30);
    check_counts("after_reset", 0, 0, 0);
    drive(2'b00, K_CW, 12);
    check_counts("after_reset_step", 1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    check_int("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
